// File: rtl/audio_meter_pkg.sv
// Shared defaults and width helpers for the audio level meter.
package audio_meter_pkg;

  localparam int DefSampleW  = 16;
  localparam int DefNumCh    = 2;
  localparam int DefBarW     = 15;
  localparam int DefHoldCyc  = 50_000_000;
  localparam int DefDecayCyc = 1_562_500;
  localparam int DefBlinkW   = 26;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Width of an index/counter that must reach n-1; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/level_chan.sv
// One meter channel: scaled magnitude, peak with hold and decay, sticky clip flag.
module level_chan
  import audio_meter_pkg::*;
#(
  parameter int SAMPLE_W  = DefSampleW,
  parameter int HOLD_CYC  = DefHoldCyc,
  parameter int DECAY_CYC = DefDecayCyc,
  parameter int ScaleW    = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                sample_valid_i,
  input  logic                pause_i,
  input  logic                clip_clr_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic [ScaleW-1:0]   scale_i,
  output logic [SAMPLE_W-2:0] mag_o,
  output logic [SAMPLE_W-2:0] peak_o,
  output logic                clip_o
);

  localparam int MagW   = SAMPLE_W - 1;
  localparam int HoldW  = idx_w(HOLD_CYC);
  localparam int DecayW = idx_w(DECAY_CYC);
  localparam logic [SAMPLE_W-1:0] MinVal   = {1'b1, {MagW{1'b0}}};
  localparam logic [SAMPLE_W-1:0] MaxVal   = {1'b0, {MagW{1'b1}}};
  localparam logic [ScaleW-1:0]   MaxShift = ScaleW'(MagW);

  logic                       take;
  logic                       clip_set;
  logic [ScaleW-1:0]          shamt;
  logic signed [SAMPLE_W-1:0] shifted;
  logic [MagW-1:0]            mag_new;
  logic [MagW-1:0]            peak_shr;
  logic [MagW-1:0]            decay_step;
  logic [MagW-1:0]            mag_q, mag_d;
  logic [MagW-1:0]            peak_q, peak_d;
  logic [HoldW-1:0]           hold_q, hold_d;
  logic [DecayW-1:0]          decay_q, decay_d;
  logic                       clip_q, clip_d;

  assign take     = sample_valid_i & ~pause_i;
  assign clip_set = take & ((sample_i == MaxVal) | (sample_i == MinVal));

  always_comb begin
    shamt   = (scale_i > MaxShift) ? MaxShift : scale_i;
    shifted = $signed(sample_i) >>> shamt;
    if (!shifted[SAMPLE_W-1]) begin
      mag_new = shifted[MagW-1:0];
    end else if ($unsigned(shifted) == MinVal) begin
      mag_new = '1;
    end else begin
      mag_new = MagW'(-shifted);
    end
  end

  always_comb begin
    peak_shr   = peak_q >> 4;
    decay_step = (peak_shr == '0) ? MagW'(1) : peak_shr;
    mag_d      = take ? mag_new : mag_q;
    peak_d     = peak_q;
    hold_d     = hold_q;
    decay_d    = decay_q;
    if (!pause_i) begin
      // A fresh maximum always beats a coincident decay step.
      if (take && (mag_new > peak_q)) begin
        peak_d  = mag_new;
        hold_d  = HoldW'(HOLD_CYC - 1);
        decay_d = '0;
      end else if (hold_q != '0) begin
        hold_d  = hold_q - HoldW'(1);
        decay_d = '0;
      end else if (decay_q == DecayW'(DECAY_CYC - 1)) begin
        decay_d = '0;
        if (peak_q != '0) begin
          peak_d = peak_q - decay_step;
        end
      end else begin
        decay_d = decay_q + DecayW'(1);
      end
    end
    clip_d = clip_set ? 1'b1 : (clip_clr_i ? 1'b0 : clip_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mag_q   <= '0;
      peak_q  <= '0;
      hold_q  <= '0;
      decay_q <= '0;
      clip_q  <= 1'b0;
    end else begin
      mag_q   <= mag_d;
      peak_q  <= peak_d;
      hold_q  <= hold_d;
      decay_q <= decay_d;
      clip_q  <= clip_d;
    end
  end

  assign mag_o  = mag_q;
  assign peak_o = peak_q;
  assign clip_o = clip_q;

endmodule

// File: rtl/audio_level_meter.sv
// Multi-channel audio level meter: per-channel datapaths, selected-channel bar graph
// with peak marker, sticky clip flags and a blinking pause indicator.
module audio_level_meter
  import audio_meter_pkg::*;
#(
  parameter int SAMPLE_W  = DefSampleW,
  parameter int NUM_CH    = DefNumCh,
  parameter int BAR_W     = DefBarW,
  parameter int HOLD_CYC  = DefHoldCyc,
  parameter int DECAY_CYC = DefDecayCyc,
  parameter int BLINK_W   = DefBlinkW
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sample_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0] sample_data,
  input  logic [clog2(SAMPLE_W)-1:0] scale,
  input  logic [idx_w(NUM_CH)-1:0]   ch_sel,
  input  logic                       pause,
  input  logic                       clip_clr,
  output logic [SAMPLE_W-2:0]        level,
  output logic [BAR_W-1:0]           bar,
  output logic [BAR_W-1:0]           peak_dot,
  output logic [NUM_CH-1:0]          clip,
  output logic                       pause_led
);

  localparam int ScaleW = clog2(SAMPLE_W);
  localparam int SelW   = idx_w(NUM_CH);
  localparam int MagW   = SAMPLE_W - 1;
  localparam int BarLsb = SAMPLE_W - 1 - BAR_W;

  logic [MagW-1:0]    mag [NUM_CH];
  logic [MagW-1:0]    peak [NUM_CH];
  logic [MagW-1:0]    peak_sel;
  logic [BAR_W-1:0]   peak_bar;
  logic [BAR_W-1:0]   bar_q, bar_d;
  logic [BAR_W-1:0]   dot_q, dot_d;
  logic [BLINK_W-1:0] blink_q;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
      level_chan #(
        .SAMPLE_W (SAMPLE_W),
        .HOLD_CYC (HOLD_CYC),
        .DECAY_CYC(DECAY_CYC),
        .ScaleW   (ScaleW)
      ) u_chan (
        .clk_i         (clk),
        .rst_ni        (reset_n),
        .sample_valid_i(sample_valid),
        .pause_i       (pause),
        .clip_clr_i    (clip_clr),
        .sample_i      (sample_data[c*SAMPLE_W +: SAMPLE_W]),
        .scale_i       (scale),
        .mag_o         (mag[c]),
        .peak_o        (peak[c]),
        .clip_o        (clip[c])
      );
    end
  endgenerate

  always_comb begin
    level    = '0;
    peak_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel == SelW'(c)) begin
        level    = mag[c];
        peak_sel = peak[c];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < BAR_W; i++) begin
      bar_d[i]    = (level >> (BarLsb + i)) != '0;
      peak_bar[i] = (peak_sel >> (BarLsb + i)) != '0;
    end
    // The peak bar is a thermometer, so its top set bit is where it differs from its own shift.
    dot_d = peak_bar & ~(peak_bar >> 1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bar_q   <= '0;
      dot_q   <= '0;
      blink_q <= '0;
    end else begin
      bar_q   <= bar_d;
      dot_q   <= dot_d;
      blink_q <= blink_q + BLINK_W'(1);
    end
  end

  assign bar       = bar_q;
  assign peak_dot  = dot_q;
  assign pause_led = pause & blink_q[BLINK_W-1];

endmodule

// File: tb/tb_audio_level_meter.sv
// Randomized bench for audio_level_meter against an arithmetic reference model.
module tb_audio_level_meter;

  localparam int SW     = 16;
  localparam int NC     = 2;
  localparam int BW     = 15;
  localparam int HC     = 10;
  localparam int DC     = 4;
  localparam int BLW    = 4;
  localparam int MagMax = (1 << (SW - 1)) - 1;
  localparam int Off    = SW - 1 - BW;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            sample_valid = 1'b0;
  logic [NC*SW-1:0] sample_data = '0;
  logic [3:0]      scale = '0;
  logic [0:0]      ch_sel = '0;
  logic            pause = 1'b0;
  logic            clip_clr = 1'b0;
  logic [SW-2:0]   level;
  logic [BW-1:0]   bar;
  logic [BW-1:0]   peak_dot;
  logic [NC-1:0]   clip;
  logic            pause_led;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: magnitude, peak, value at last load and active cycles since it.
  int            m_mag [NC];
  int            m_peak [NC];
  int            m_lpeak [NC];
  int            m_t [NC];
  logic [NC-1:0] m_clip;
  int            m_bar;
  int            m_dot;
  int            m_cnt;

  always #5 clk = ~clk;

  audio_level_meter #(
    .SAMPLE_W (SW),
    .NUM_CH   (NC),
    .BAR_W    (BW),
    .HOLD_CYC (HC),
    .DECAY_CYC(DC),
    .BLINK_W  (BLW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .scale       (scale),
    .ch_sel      (ch_sel),
    .pause       (pause),
    .clip_clr    (clip_clr),
    .level       (level),
    .bar         (bar),
    .peak_dot    (peak_dot),
    .clip        (clip),
    .pause_led   (pause_led)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mag_of(input logic [SW-1:0] s, input int sc);
    int v;
    v = int'($signed(s));
    if (sc > SW - 1) sc = SW - 1;
    v = v >>> sc;
    if (v < 0) v = -v;
    if (v > MagMax) v = MagMax;
    return v;
  endfunction

  function automatic int thermo(input int l);
    int r;
    r = 0;
    for (int i = 0; i < BW; i++) begin
      if (l >= (1 << (Off + i))) r |= (1 << i);
    end
    return r;
  endfunction

  function automatic int dot_of(input int p);
    int r;
    r = 0;
    for (int i = 0; i < BW; i++) begin
      if (p >= (1 << (Off + i))) r = (1 << i);
    end
    return r;
  endfunction

  // Peak after t active cycles: held HC-1 cycles, then one step per DC cycles.
  function automatic int decayed(input int lp, input int t);
    int n;
    int p;
    int s;
    n = (t < HC - 1) ? 0 : (t - (HC - 1)) / DC;
    p = lp;
    for (int k = 0; k < n && p > 0; k++) begin
      s = (p / 16 > 1) ? p / 16 : 1;
      p = (p > s) ? p - s : 0;
    end
    return p;
  endfunction

  function automatic bit is_extreme(input logic [SW-1:0] v);
    return (v == 16'h7FFF) || (v == 16'h8000);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_mag[c]   = 0;
      m_peak[c]  = 0;
      m_lpeak[c] = 0;
      m_t[c]     = 0;
    end
    m_clip = '0;
    m_bar  = 0;
    m_dot  = 0;
    m_cnt  = 0;
  endtask

  task automatic model_update();
    int nm;
    logic [SW-1:0] s;
    m_bar = thermo(m_mag[ch_sel]);
    m_dot = dot_of(m_peak[ch_sel]);
    for (int c = 0; c < NC; c++) begin
      s = sample_data[c*SW +: SW];
      if (!pause) begin
        nm = mag_of(s, int'(scale));
        if (sample_valid) m_mag[c] = nm;
        if (sample_valid && nm > m_peak[c]) begin
          m_lpeak[c] = nm;
          m_t[c]     = 0;
          m_peak[c]  = nm;
        end else begin
          m_t[c]++;
          m_peak[c] = decayed(m_lpeak[c], m_t[c]);
        end
      end
      if (!pause && sample_valid && is_extreme(s)) m_clip[c] = 1'b1;
      else if (clip_clr) m_clip[c] = 1'b0;
    end
    m_cnt = (m_cnt + 1) % (1 << BLW);
  endtask

  task automatic compare_all();
    check_eq("level", 32'(level), 32'(m_mag[ch_sel]));
    check_eq("bar", 32'(bar), 32'(m_bar));
    check_eq("peak_dot", 32'(peak_dot), 32'(m_dot));
    check_eq("clip", 32'(clip), 32'(m_clip));
    check_eq("pause_led", 32'(pause_led), pause ? 32'((m_cnt >> (BLW - 1)) & 1) : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse();
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_level"}, 32'(level), 32'd0);
    check_eq({tag, "_bar"}, 32'(bar), 32'd0);
    check_eq({tag, "_dot"}, 32'(peak_dot), 32'd0);
    check_eq({tag, "_clip"}, 32'(clip), 32'd0);
    check_eq({tag, "_led"}, 32'(pause_led), 32'd0);
  endtask

  function automatic logic [SW-1:0] rand_sample();
    case ($urandom_range(0, 3))
      0:       return ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
      1:       return 16'($urandom_range(0, 511) - 256);
      2:       return 16'($urandom);
      default: return '0;
    endcase
  endfunction

  initial begin
    bit seen0;
    bit seen1;
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Full-scale negative on ch0.
    sample_data[0 +: SW] = 16'h8000;
    pulse();
    sample_data = '0;
    tick();
    check_eq("s024_level", 32'(level), 32'd32767);
    check_eq("s024_bar", 32'(bar), 32'h7FFF);
    check_eq("s024_clip0", 32'(clip[0]), 32'd1);

    // Scaled positive on ch1.
    scale  = 4'd4;
    ch_sel = 1'b1;
    sample_data[SW +: SW] = 16'h1000;
    pulse();
    sample_data = '0;
    tick();
    check_eq("s025_level", 32'(level), 32'h0100);
    check_eq("s025_bar", 32'(bar), 32'h01FF);

    // Long idle so the ch0 peak decays partway, then reset during decay.
    ch_sel = 1'b0;
    scale  = 4'd0;
    for (int k = 0; k < 300; k++) begin
      sample_valid = ($urandom_range(0, 7) == 0);
      tick();
    end
    sample_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_zero("midreset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    sample_data[0 +: SW] = 16'h0010;
    pulse();
    sample_data = '0;
    tick();
    check_eq("s029_level", 32'(level), 32'h0010);
    check_eq("s029_dot", 32'(peak_dot), 32'h0010);

    // New maximum lands on the same edge as a decay step.
    sample_data[0 +: SW] = 16'h1000;
    pulse();
    sample_data = '0;
    repeat (12) tick();
    sample_data[0 +: SW] = 16'h2000;
    pulse();
    sample_data = '0;
    tick();
    check_eq("s027_dot", 32'(peak_dot), 32'h2000);
    repeat (4) tick();
    check_eq("s027_hold", 32'(peak_dot), 32'h2000);

    // Paused: samples ignored, clip clear still works, led blinks.
    pause = 1'b1;
    seen0 = 1'b0;
    seen1 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      sample_valid = ($urandom_range(0, 1) != 0);
      for (int c = 0; c < NC; c++) sample_data[c*SW +: SW] = 16'h7FFF;
      clip_clr = (k == 20);
      tick();
      if (pause_led) seen1 = 1'b1;
      else seen0 = 1'b1;
    end
    check_eq("pause_clip", 32'(clip), 32'd0);
    check_eq("pause_blink", 32'(seen0 && seen1), 32'd1);
    pause        = 1'b0;
    clip_clr     = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;

    // Random traffic, alternating busy and sparse blocks so decay is exercised.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 49) == 0) pause = ~pause;
      if (((k / 500) % 2) == 0) sample_valid = ($urandom_range(0, 3) == 0);
      else sample_valid = ($urandom_range(0, 63) == 0);
      clip_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) ch_sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) begin
        scale = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      for (int c = 0; c < NC; c++) sample_data[c*SW +: SW] = rand_sample();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
